// File: rtl/adapter_xfer_ctrl_if.sv
// Handshake bundle between the adapter transaction controller and its
// surrounding FIFOs, command sinks and far-side credit logic.
//
// Valid/ready semantics: a *_o strobe is a valid that depends only on
// registered controller state plus FIFO-availability inputs, never on its
// own ready. A transfer happens on a rising clock edge where strobe and
// ready are both high. A strobe that is not accepted stays asserted for as
// long as its conditions hold.
interface adapter_xfer_ctrl_if;
  logic tx_detc_i;
  logic rx_detc_i;
  logic tx_resp_detc_i;
  logic rx_resp_detc_i;
  logic wr_fifo_rd_ready;
  logic rd_fifo_rd_ready;
  logic tx_cmd_ready;
  logic rx_cmd_ready;
  logic tx_resp_cmd_ready;
  logic rx_resp_cmd_ready;
  logic tx_crd_i;
  logic rx_crd_ready;
  logic tx_cmd_o;
  logic rx_cmd_o;
  logic tx_resp_cmd_o;
  logic rx_resp_cmd_o;
  logic rx_crd_o;

  // Controller side
  modport master (
    input  tx_detc_i, rx_detc_i, tx_resp_detc_i, rx_resp_detc_i,
           wr_fifo_rd_ready, rd_fifo_rd_ready, tx_cmd_ready, rx_cmd_ready,
           tx_resp_cmd_ready, rx_resp_cmd_ready, tx_crd_i, rx_crd_ready,
    output tx_cmd_o, rx_cmd_o, tx_resp_cmd_o, rx_resp_cmd_o, rx_crd_o
  );

  // Environment side
  modport slave (
    output tx_detc_i, rx_detc_i, tx_resp_detc_i, rx_resp_detc_i,
           wr_fifo_rd_ready, rd_fifo_rd_ready, tx_cmd_ready, rx_cmd_ready,
           tx_resp_cmd_ready, rx_resp_cmd_ready, tx_crd_i, rx_crd_ready,
    input  tx_cmd_o, rx_cmd_o, tx_resp_cmd_o, rx_resp_cmd_o, rx_crd_o
  );
endinterface

// File: rtl/adapter_xfer_ctrl.sv
// Adapter transaction/credit controller: one write or read transaction at a
// time (request -> data phase -> response handshake), TX command gating on a
// far-side credit pool, RX credit return, and a no-progress watchdog.
module adapter_xfer_ctrl #(
  parameter int CRD_W    = 7,
  parameter int CRD_INIT = 127,
  parameter int TO_W     = 10,
  parameter int TO_CYC   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  adapter_xfer_ctrl_if.master bus,
  input  logic                err_clr_i,
  output logic                lp_irdy_o,
  output logic                err_o,
  output logic [2:0]          cur_state_o,
  output logic [CRD_W-1:0]    credit_tx_o,
  output logic [CRD_W-1:0]    credit_rx_o
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ       = 3'd2,
    ST_WRITE_RESP = 3'd3,
    ST_READ_RESP  = 3'd4,
    ST_ERROR      = 3'd5
  } state_e;

  localparam logic [CRD_W-1:0] CRD_INIT_V = CRD_W'(CRD_INIT);
  localparam logic [CRD_W-1:0] CRD_MAX    = {CRD_W{1'b1}};
  localparam bit               WD_EN      = (TO_CYC != 0);
  // Watchdog fires when the cycle about to complete is the TO_CYC-th idle one.
  localparam logic [TO_W-1:0]  WD_LAST    = TO_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);

  state_e           state_q, state_d;
  logic [CRD_W-1:0] credit_tx_q, credit_tx_d;
  logic [CRD_W-1:0] credit_rx_q, credit_rx_d;
  logic [TO_W-1:0]  wd_q, wd_d;

  logic tx_cmd, rx_cmd, rx_crd;
  logic tx_xfer, rx_xfer, crd_xfer;
  logic wd_expire;

  // Strobe decode and transfer detection from registered state/counters.
  always_comb begin
    tx_cmd    = (state_q == ST_WRITE) && bus.wr_fifo_rd_ready && (credit_tx_q != '0);
    rx_cmd    = (state_q == ST_READ) && bus.rd_fifo_rd_ready && (credit_rx_q != CRD_MAX);
    rx_crd    = (credit_rx_q != '0);
    tx_xfer   = tx_cmd && bus.tx_cmd_ready;
    rx_xfer   = rx_cmd && bus.rx_cmd_ready;
    crd_xfer  = rx_crd && bus.rx_crd_ready;
    wd_expire = WD_EN && !tx_xfer && !rx_xfer && (wd_q == WD_LAST);
  end

  // Next-state selection; response detection beats watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_detc_i)      state_d = ST_READ;
        else if (bus.tx_detc_i) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.tx_resp_detc_i) state_d = ST_WRITE_RESP;
        else if (wd_expire)     state_d = ST_ERROR;
      end
      ST_READ: begin
        if (bus.rx_resp_detc_i) state_d = ST_READ_RESP;
        else if (wd_expire)     state_d = ST_ERROR;
      end
      ST_WRITE_RESP: if (bus.tx_resp_cmd_ready) state_d = ST_IDLE;
      ST_READ_RESP:  if (bus.rx_resp_cmd_ready) state_d = ST_IDLE;
      ST_ERROR:      if (err_clr_i)             state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Counter updates: TX pool reloads in IDLE and saturates at CRD_INIT;
  // RX pool carries across transactions; watchdog counts idle data cycles.
  always_comb begin
    credit_tx_d = credit_tx_q;
    credit_rx_d = credit_rx_q;
    wd_d        = '0;

    if (state_q == ST_IDLE) begin
      credit_tx_d = CRD_INIT_V;
    end else if (tx_xfer && !bus.tx_crd_i) begin
      credit_tx_d = credit_tx_q - 1'b1;
    end else if (!tx_xfer && bus.tx_crd_i && (credit_tx_q < CRD_INIT_V)) begin
      credit_tx_d = credit_tx_q + 1'b1;
    end

    if (rx_xfer && !crd_xfer) begin
      credit_rx_d = credit_rx_q + 1'b1;
    end else if (!rx_xfer && crd_xfer) begin
      credit_rx_d = credit_rx_q - 1'b1;
    end

    if (WD_EN && (state_d == state_q) && !tx_xfer && !rx_xfer &&
        ((state_q == ST_WRITE) || (state_q == ST_READ))) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      credit_tx_q <= CRD_INIT_V;
      credit_rx_q <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      credit_tx_q <= credit_tx_d;
      credit_rx_q <= credit_rx_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.tx_cmd_o      = tx_cmd;
  assign bus.rx_cmd_o      = rx_cmd;
  assign bus.rx_crd_o      = rx_crd;
  assign bus.tx_resp_cmd_o = (state_q == ST_WRITE_RESP);
  assign bus.rx_resp_cmd_o = (state_q == ST_READ_RESP);
  assign lp_irdy_o         = (state_q == ST_WRITE);
  assign err_o             = (state_q == ST_ERROR);
  assign cur_state_o       = state_q;
  assign credit_tx_o       = credit_tx_q;
  assign credit_rx_o       = credit_rx_q;

endmodule

// File: doc/adapter_xfer_ctrl.md
# adapter_xfer_ctrl

Parametrised transaction/credit controller for the LPDDR4 adapter layer, replacing the fixed 7-bit adapter FSM. It sequences one write or read transaction at a time: IDLE, then data phase, then response handshake. It gates TX commands on a configurable far-side credit pool and returns RX credits for every accepted RX command. It also adds response handshaking, a no-progress watchdog with an ERROR state, and credit saturation.

## Interface
- CRD_W, 7, width of both credit counters
- CRD_INIT, 127, TX credit reload value; must be ≤ 2^CRD_W−1
- TO_W, 10, watchdog counter width
- TO_CYC, 1000, idle cycles in WRITE/READ before ERROR; 0 disables; must be < 2^TO_W

- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- tx_detc_i / rx_detc_i  in  1  write / read transaction request (sampled in IDLE)
- tx_resp_detc_i / rx_resp_detc_i  in  1  write / read response detected
- wr_fifo_rd_ready / rd_fifo_rd_ready  in  1  write / read data FIFO has a beat available
- tx_cmd_ready / rx_cmd_ready  in  1  sink accepts tx_cmd_o / rx_cmd_o
- tx_resp_cmd_ready / rx_resp_cmd_ready  in  1  sink accepts response command
- tx_crd_i  in  1  one TX credit returned by far side (pulse, counted per cycle)
- rx_crd_ready  in  1  far side accepts rx_crd_o
- err_clr_i  in  1  clears ERROR
- tx_cmd_o, rx_cmd_o, tx_resp_cmd_o, rx_resp_cmd_o, rx_crd_o  out  1  valid strobes
- lp_irdy_o  out  1  high in WRITE
- err_o  out  1  high in ERROR
- cur_state_o  out  3  state encoding
- credit_tx_o / credit_rx_o  out  CRD_W  current counters

## Operation
- States: IDLE=0, WRITE=1, READ=2, WRITE_RESP=3, READ_RESP=4, ERROR=5; 6/7 → IDLE next cycle.
- IDLE: rx_detc_i → READ (priority); else tx_detc_i → WRITE; else stay.
- WRITE: tx_resp_detc_i → WRITE_RESP; watchdog expiry → ERROR; resp_detc wins if both fire in the same cycle. READ is symmetric with rx_resp_detc_i.
- WRITE_RESP: tx_resp_cmd_o=1; leave to IDLE on the cycle tx_resp_cmd_ready=1. READ_RESP is symmetric. No watchdog in RESP states.
- ERROR: err_o=1, all cmd strobes 0; err_clr_i → IDLE.
- tx_cmd_o = (WRITE) & wr_fifo_rd_ready & (credit_tx≠0). rx_cmd_o = (READ) & rd_fifo_rd_ready & (credit_rx≠2^CRD_W−1).
- Transfer = strobe & its ready, counted on the clock edge.
- credit_tx: reloads CRD_INIT whenever state=IDLE. Otherwise:
  - −1 on TX transfer
  - +1 on tx_crd_i
  - both in the same cycle → unchanged
  - increment at CRD_INIT is dropped (saturate)
- credit_rx: not cleared by IDLE, so pending credits drain across transactions. Updates:
  - +1 on RX transfer
  - −1 on rx_crd_o & rx_crd_ready
  - both in the same cycle → unchanged
- rx_crd_o = (credit_rx≠0) in every state, including ERROR.
- Watchdog:
  - clears on state entry and on any TX/RX transfer
  - otherwise increments in WRITE/READ
  - reaching TO_CYC forces ERROR on the next edge
- rst=1 mid-transaction: next edge gives IDLE, credit_tx=CRD_INIT, credit_rx=0, watchdog=0. Strobes drop that cycle because they are decoded from state.

## Timing
- All outputs are combinational decodes of registered state/counters plus ready/FIFO inputs; no registered strobe delay.
- Reset values: cur_state_o=0, credit_tx_o=CRD_INIT, credit_rx_o=0, err_o=0, all strobes 0, lp_irdy_o=0.
- Detect to first command: request seen in IDLE at edge N → state WRITE/READ in cycle N+1 → tx_cmd_o/rx_cmd_o can assert in cycle N+1.
- A counter change is visible on credit_*_o the cycle after the transfer. With credit_tx=1, a transfer at edge N makes tx_cmd_o=0 from cycle N+1.
- Response-command handshake: the strobe stays high until ready; the state changes on the accepting edge.

## Test plan
- Write, CRD_INIT=4, no tx_crd_i, FIFO and tx_cmd_ready always 1 → exactly 4 tx_cmd transfers, then tx_cmd_o=0 with credit_tx_o=0. Pulse tx_crd_i once → one more transfer. tx_resp_detc_i → WRITE_RESP; hold tx_resp_cmd_ready=0 for 3 cycles → tx_resp_cmd_o held for 3 cycles, then IDLE.
- Simultaneous TX transfer and tx_crd_i at credit_tx=5 → stays 5. tx_crd_i at credit_tx=CRD_INIT → stays CRD_INIT.
- Read of 3 beats with rx_crd_ready=0 → credit_rx_o=3 and rx_crd_o=1. Go to IDLE, then raise rx_crd_ready → 3 credit transfers, credit_rx_o=0, rx_crd_o=0.
- rx_detc_i and tx_detc_i both high in IDLE → READ (cur_state_o=2).
- TO_CYC=8 in WRITE with wr_fifo_rd_ready=0 → ERROR after 8 cycles, err_o=1, lp_irdy_o=0. err_clr_i → IDLE, credit_tx_o=CRD_INIT.
- rst asserted in WRITE with credit_tx=2, credit_rx=1 → next cycle IDLE, credit_tx_o=CRD_INIT, credit_rx_o=0, all strobes 0.
